// File: rtl/ii_window_loader.sv
// ---------------------------------------------------------------------------
// ii_window_loader
//   Feeder for the Haar cascade classifier. Accepts a WIN x WIN window of
//   pixels in raster order, builds the (WIN+1)x(WIN+1) integral image (zero
//   first row and column) and writes it into the classifier II RAM. It then
//   derives the variance normalisation factor, pulses start_o to the cascade,
//   waits for done_i and hands the classification result back upstream.
//
// Ports
//   clk_i, rst_i            clock / asynchronous active-low reset
//   load_i                  start a window load (honoured in IDLE only)
//   pixel_data_i/_val_i     pixel stream input; pixel_rdy_o is the ready
//   ii_addr_wr_o/_data_wr_o/_val_wr_o   II RAM write port
//   variance_norm_factor_o  floor(sqrt(WIN^2*sum(p^2) - sum(p)^2)), min 1
//   start_o                 one-cycle cascade start
//   done_i, result_i        cascade completion and its result
//   busy_o                  high whenever the FSM is not IDLE
//   result_o, result_val_o  captured result and its one-cycle update strobe
// ---------------------------------------------------------------------------
module ii_window_loader #(
    parameter int LENGHT_LINE_II = 21,
    parameter int ADDR_WIDTH_II  = $clog2(LENGHT_LINE_II**2),
    parameter int PIXEL_WIDTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic [PIXEL_WIDTH-1:0]   pixel_data_i,
    input  logic                     pixel_val_i,
    output logic                     pixel_rdy_o,
    output logic [ADDR_WIDTH_II-1:0] ii_addr_wr_o,
    output logic [31:0]              ii_data_wr_o,
    output logic                     ii_val_wr_o,
    output logic [31:0]              variance_norm_factor_o,
    output logic                     start_o,
    input  logic                     done_i,
    input  logic                     result_i,
    output logic                     busy_o,
    output logic                     result_o,
    output logic                     result_val_o
);

    localparam int WIN = LENGHT_LINE_II - 1;
    localparam int AW  = ADDR_WIDTH_II;
    // Counter must hold both 0..WIN and the 20 sqrt iterations.
    localparam int CW  = ($clog2(LENGHT_LINE_II) > 5) ? $clog2(LENGHT_LINE_II) : 5;

    // Square root: 40-bit radicand, 2 bits per cycle -> 20 iterations.
    localparam int RW       = 40;
    localparam int SQW      = RW / 2;
    localparam int RMW      = SQW + 2;
    localparam int SQ_STEPS = SQW;

    localparam logic [CW-1:0] C_WIN     = CW'(WIN);
    localparam logic [CW-1:0] C_WIN_M1  = CW'(WIN - 1);
    localparam logic [CW-1:0] C_SQ_LAST = CW'(SQ_STEPS - 1);
    localparam logic [AW-1:0] C_LINE    = AW'(LENGHT_LINE_II);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_COL0, S_PIX, S_NORM, S_SQRT, S_START, S_WAIT, S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [AW-1:0]  r_row_base;   // (row+1)*LENGHT_LINE_II, tracked incrementally
    logic [31:0]    r_rowsum;
    logic [31:0]    r_lb [WIN];   // II values of the previous II row, columns 1..WIN
    logic [31:0]    r_sum;
    logic [31:0]    r_sqsum;

    logic [RW-1:0]  r_rad;
    logic [RMW-1:0] r_rem;
    logic [SQW-1:0] r_root;

    logic [AW-1:0]  r_ii_addr;
    logic [31:0]    r_ii_data;
    logic           r_ii_val;
    logic [31:0]    r_factor;
    logic           r_result;

    logic           w_xfer;
    logic [31:0]    w_pix;
    logic [31:0]    w_rowsum_nxt;
    logic [31:0]    w_ii;
    logic [RW-1:0]  w_sq_a;
    logic [RW-1:0]  w_sq_b;
    logic signed [RW-1:0] w_nf;
    logic [RW-1:0]  w_rad;
    logic [RMW-1:0] w_rem_nxt;
    logic [SQW-1:0] w_root_nxt;

    // One restoring-sqrt iteration: bring down two radicand bits, try to
    // subtract (4*root + 1), and shift the resulting root bit in.
    function automatic logic [RMW+SQW-1:0] sqrt_step(
        input logic [RMW-1:0] rem,
        input logic [SQW-1:0] root,
        input logic [1:0]     bits
    );
        logic [RMW+1:0] t;
        logic [RMW+1:0] trial;
        t     = {rem, bits};
        trial = (RMW+2)'({root, 2'b01});
        if (t >= trial)
            sqrt_step = {RMW'(t - trial), root[SQW-2:0], 1'b1};
        else
            sqrt_step = {RMW'(t), root[SQW-2:0], 1'b0};
    endfunction

    // A non-positive variance would make the cascade divide by zero, so the
    // radicand is clamped to 1.
    function automatic logic [RW-1:0] clamp_radicand(input logic signed [RW-1:0] nf);
        clamp_radicand = (nf <= 0) ? RW'(1) : $unsigned(nf);
    endfunction

    assign w_xfer       = (r_state == S_PIX) && pixel_val_i;
    assign w_pix        = 32'(pixel_data_i);
    assign w_rowsum_nxt = r_rowsum + w_pix;
    assign w_ii         = r_lb[r_col] + w_rowsum_nxt;

    assign w_sq_a = RW'(WIN * WIN) * RW'(r_sqsum);
    assign w_sq_b = RW'(r_sum) * RW'(r_sum);
    assign w_nf   = $signed(w_sq_a - w_sq_b);
    assign w_rad  = clamp_radicand(w_nf);

    assign {w_rem_nxt, w_root_nxt} = sqrt_step(r_rem, r_root, r_rad[RW-1:RW-2]);

    assign ii_addr_wr_o           = r_ii_addr;
    assign ii_data_wr_o           = r_ii_data;
    assign ii_val_wr_o            = r_ii_val;
    assign variance_norm_factor_o = r_factor;
    assign result_o               = r_result;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        pixel_rdy_o  = 1'b0;
        start_o      = 1'b0;
        result_val_o = 1'b0;
        busy_o       = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (load_i) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: if (r_cnt == C_WIN) w_state_nxt = S_COL0;
            S_COL0:  w_state_nxt = S_PIX;
            S_PIX: begin
                pixel_rdy_o = 1'b1;
                if (w_xfer && (r_col == C_WIN_M1))
                    w_state_nxt = (r_row == C_WIN_M1) ? S_NORM : S_COL0;
            end
            S_NORM:  w_state_nxt = S_SQRT;
            S_SQRT:  if (r_cnt == C_SQ_LAST) w_state_nxt = S_START;
            S_START: begin
                start_o     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT:  if (done_i) w_state_nxt = S_DONE;
            S_DONE: begin
                result_val_o = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_rowsum   <= '0;
            for (int i = 0; i < WIN; i++) r_lb[i] <= '0;
            r_sum      <= '0;
            r_sqsum    <= '0;
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_ii_addr  <= '0;
            r_ii_data  <= '0;
            r_ii_val   <= 1'b0;
            r_factor   <= '0;
            r_result   <= 1'b0;
        end else begin
            r_ii_val <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_i) begin
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_sqsum <= '0;
                    end
                end
                // Row 0 of the II is all zero; the line buffer starts the
                // first pixel row from an all-zero previous row.
                S_CLEAR: begin
                    r_ii_val  <= 1'b1;
                    r_ii_addr <= AW'(r_cnt);
                    r_ii_data <= '0;
                    r_cnt     <= r_cnt + 1'b1;
                    for (int i = 0; i < WIN; i++) r_lb[i] <= '0;
                    if (r_cnt == C_WIN) begin
                        r_row      <= '0;
                        r_row_base <= C_LINE;
                    end
                end
                S_COL0: begin
                    r_ii_val  <= 1'b1;
                    r_ii_addr <= r_row_base;
                    r_ii_data <= '0;
                    r_col     <= '0;
                    r_rowsum  <= '0;
                end
                S_PIX: begin
                    if (w_xfer) begin
                        r_rowsum    <= w_rowsum_nxt;
                        r_lb[r_col] <= w_ii;
                        r_ii_val    <= 1'b1;
                        r_ii_addr   <= r_row_base + AW'(r_col) + AW'(1);
                        r_ii_data   <= w_ii;
                        r_sum       <= r_sum + w_pix;
                        r_sqsum     <= r_sqsum + w_pix * w_pix;
                        if (r_col == C_WIN_M1) begin
                            if (r_row != C_WIN_M1) begin
                                r_row      <= r_row + 1'b1;
                                r_row_base <= r_row_base + C_LINE;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_NORM: begin
                    r_rad  <= w_rad;
                    r_rem  <= '0;
                    r_root <= '0;
                    r_cnt  <= '0;
                end
                S_SQRT: begin
                    r_rad  <= {r_rad[RW-3:0], 2'b00};
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_SQ_LAST) r_factor <= 32'(w_root_nxt);
                end
                S_WAIT: begin
                    if (done_i) r_result <= result_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ii_window_loader.sv
module tb_ii_window_loader;

    localparam int L   = 21;
    localparam int WIN = L - 1;
    localparam int NPX = WIN * WIN;
    localparam int NII = L * L;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        load_i;
    logic [7:0]  pixel_data_i;
    logic        pixel_val_i;
    logic        pixel_rdy_o;
    logic [8:0]  ii_addr_wr_o;
    logic [31:0] ii_data_wr_o;
    logic        ii_val_wr_o;
    logic [31:0] variance_norm_factor_o;
    logic        start_o;
    logic        done_i;
    logic        result_i;
    logic        busy_o;
    logic        result_o;
    logic        result_val_o;

    ii_window_loader #(.LENGHT_LINE_II(L), .ADDR_WIDTH_II(9), .PIXEL_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i),
        .pixel_data_i(pixel_data_i), .pixel_val_i(pixel_val_i), .pixel_rdy_o(pixel_rdy_o),
        .ii_addr_wr_o(ii_addr_wr_o), .ii_data_wr_o(ii_data_wr_o), .ii_val_wr_o(ii_val_wr_o),
        .variance_norm_factor_o(variance_norm_factor_o), .start_o(start_o),
        .done_i(done_i), .result_i(result_i), .busy_o(busy_o),
        .result_o(result_o), .result_val_o(result_val_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_chk = 0;
    int     n_err = 0;
    int     pix [NPX];
    longint exp_ii [NII];
    longint exp_fac;
    int     wr_cnt [NII];
    longint wr_data [NII];
    int     wr_total;
    int     start_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Observe the write port and start pulses away from the active edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (ii_val_wr_o) begin
                wr_total++;
                if (int'(ii_addr_wr_o) < NII) begin
                    wr_cnt[int'(ii_addr_wr_o)]++;
                    wr_data[int'(ii_addr_wr_o)] = longint'(ii_data_wr_o);
                end
            end
            if (start_o) start_cnt++;
        end
    end

    // mode: 0 zeros, 1 ones, 2 checkerboard 0/255, 3 random
    task automatic gen(input int mode);
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                case (mode)
                    0: pix[r*WIN+c] = 0;
                    1: pix[r*WIN+c] = 1;
                    2: pix[r*WIN+c] = ((r + c) % 2 == 1) ? 255 : 0;
                    default: pix[r*WIN+c] = int'($urandom_range(255));
                endcase
    endtask

    // II(y,x) = sum of pixels strictly above-left; factor = floor sqrt of
    // N*sum(p^2) - sum(p)^2, clamped to a minimum radicand of 1.
    task automatic build_model();
        longint s, sq, nf, lo, hi, mid;
        s = 0; sq = 0;
        for (int i = 0; i < NPX; i++) begin
            s  += pix[i];
            sq += longint'(pix[i]) * pix[i];
        end
        for (int y = 0; y < L; y++)
            for (int x = 0; x < L; x++) begin
                longint acc = 0;
                for (int r = 0; r < y; r++)
                    for (int c = 0; c < x; c++)
                        acc += pix[r*WIN+c];
                exp_ii[y*L+x] = acc;
            end
        nf = longint'(NPX) * sq - s * s;
        if (nf <= 0) nf = 1;
        lo = 0; hi = 64'd1 << 21;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= nf) lo = mid;
            else hi = mid - 1;
        end
        exp_fac = lo;
    endtask

    // Starts at a negedge with the FSM idle; returns at a negedge after
    // stop_after pixels have been accepted.
    task automatic load_and_feed(input int gap_pct, input int stop_after);
        int  idx, guard;
        bit  v, acc, row_end;
        for (int a = 0; a < NII; a++) begin wr_cnt[a] = 0; wr_data[a] = -1; end
        wr_total = 0; start_cnt = 0;
        load_i = 1'b1;
        @(negedge clk_i);
        load_i = 1'b0;
        check("busy_after_load", busy_o, 1);
        idx = 0; guard = 0; row_end = 0;
        while (idx < stop_after && guard < 5000) begin
            if (row_end) begin
                check("rdy_col0", pixel_rdy_o, 0);
                row_end = 0;
            end
            v = ($urandom_range(99) >= gap_pct);
            pixel_val_i  = v;
            pixel_data_i = 8'(pix[idx]);
            acc = v && pixel_rdy_o;
            @(negedge clk_i);
            guard++;
            if (acc) begin
                idx++;
                if (idx % WIN == 0 && idx < NPX) row_end = 1;
            end
        end
        pixel_val_i = 1'b0;
        if (guard >= 5000) check("feed_timeout", idx, stop_after);
    endtask

    task automatic finish_window(input bit res, input bit poke_load);
        bit found = 0;
        for (int i = 0; i < 200; i++) begin
            if (start_o) begin found = 1; break; end
            @(negedge clk_i);
        end
        check("start_seen", found, 1);
        check("norm_factor", variance_norm_factor_o, exp_fac);
        @(negedge clk_i);
        check("start_one_cycle", start_o, 0);
        check("busy_wait", busy_o, 1);
        if (poke_load) begin
            load_i = 1'b1;
            @(negedge clk_i);
            load_i = 1'b0;
        end
        repeat ($urandom_range(3)) @(negedge clk_i);
        check("no_result_val_wait", result_val_o, 0);
        done_i = 1'b1; result_i = res;
        @(negedge clk_i);
        done_i = 1'b0; result_i = 1'b0;
        check("result_o", result_o, res);
        check("result_val_pulse", result_val_o, 1);
        check("busy_done", busy_o, 1);
        @(negedge clk_i);
        check("result_val_low", result_val_o, 0);
        check("busy_idle", busy_o, 0);
        check("result_held", result_o, res);
        check("factor_held", variance_norm_factor_o, exp_fac);
        check("start_count", start_cnt, 1);
        check("write_total", wr_total, NII);
        for (int a = 0; a < NII; a++) begin
            check($sformatf("wr_count[%0d]", a), wr_cnt[a], 1);
            check($sformatf("ii[%0d]", a), wr_data[a], exp_ii[a]);
        end
    endtask

    initial begin
        rst_i = 1'b0; load_i = 1'b0; pixel_data_i = '0; pixel_val_i = 1'b0;
        done_i = 1'b0; result_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_rdy", pixel_rdy_o, 0);
        check("rst_wr_val", ii_val_wr_o, 0);
        check("rst_start", start_o, 0);
        check("rst_factor", variance_norm_factor_o, 0);
        check("rst_result", result_o, 0);
        check("rst_result_val", result_val_o, 0);
        rst_i = 1'b1;
        @(negedge clk_i);

        gen(0); build_model(); load_and_feed(0, NPX);  finish_window(0, 0);
        gen(1); build_model(); load_and_feed(0, NPX);  finish_window(1, 0);
        gen(2); build_model(); load_and_feed(0, NPX);  finish_window(0, 1);
        gen(3); build_model(); load_and_feed(0, NPX);  finish_window(1, 0);

        // done_i while idle must not disturb anything
        done_i = 1'b1; result_i = 1'b0;
        @(negedge clk_i);
        done_i = 1'b0;
        check("idle_done_val", result_val_o, 0);
        check("idle_done_result", result_o, 1);
        check("idle_done_busy", busy_o, 0);

        // same random window, now with heavy valid gaps
        load_and_feed(50, NPX); finish_window(1, 0);

        // abort in the middle of row 7
        gen(3); build_model();
        load_and_feed(40, 7 * WIN + 5);
        #2 rst_i = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_rdy", pixel_rdy_o, 0);
        check("arst_wr_val", ii_val_wr_o, 0);
        check("arst_wr_addr", ii_addr_wr_o, 0);
        check("arst_wr_data", ii_data_wr_o, 0);
        check("arst_start", start_o, 0);
        check("arst_factor", variance_norm_factor_o, 0);
        check("arst_result", result_o, 0);
        check("arst_result_val", result_val_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        gen(3); build_model(); load_and_feed(30, NPX); finish_window(1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
